// File: rtl/mealy_seq_gen.sv
// Transmit-side pattern generator: emits bursts of 0,6,4,2 frames over a valid/ready bus,
// with optional inter-frame gaps and single-symbol corruption of the first frame.
module mealy_seq_gen #(
  parameter int          GAP_CYCLES = 2,
  parameter int          CNT_W      = 8,
  parameter logic [2:0]  IDLE_SYM   = 3'd7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_frames,
  input  logic             inject_err,
  input  logic [1:0]       err_pos,
  input  logic             ready,
  output logic [2:0]       sym,
  output logic             valid,
  output logic             frame_done,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] total, total_n;
  logic             inj, inj_n;
  logic [1:0]       err_idx, err_idx_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [CNT_W-1:0] sent_n, sent_inc;
  logic [2:0]       sym_n;
  logic             valid_n, frame_done_n, done_n, busy_n, accept, corrupt;

  function automatic logic [2:0] pattern_sym(input logic [1:0] i);
    case (i)
      2'd0:    pattern_sym = 3'd0;
      2'd1:    pattern_sym = 3'd6;
      2'd2:    pattern_sym = 3'd4;
      default: pattern_sym = 3'd2;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      total       <= '0;
      inj         <= 1'b0;
      err_idx     <= 2'd0;
      gap_cnt     <= '0;
      sym         <= IDLE_SYM;
      valid       <= 1'b0;
      frame_done  <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      total       <= total_n;
      inj         <= inj_n;
      err_idx     <= err_idx_n;
      gap_cnt     <= gap_cnt_n;
      sym         <= sym_n;
      valid       <= valid_n;
      frame_done  <= frame_done_n;
      done        <= done_n;
      busy        <= busy_n;
      frames_sent <= sent_n;
    end
  end

  assign accept   = valid && ready;
  assign sent_inc = frames_sent + CNT_W'(1);

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    total_n      = total;
    inj_n        = inj;
    err_idx_n    = err_idx;
    gap_cnt_n    = gap_cnt;
    sent_n       = frames_sent;
    frame_done_n = 1'b0;
    done_n       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (num_frames != '0) begin
            total_n   = num_frames;
            inj_n     = inject_err;
            err_idx_n = err_pos;
            sent_n    = '0;
            idx_n     = 2'd0;
            state_n   = SEND;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SEND: begin
        if (accept) begin
          if (idx == 2'd3) begin
            frame_done_n = 1'b1;
            sent_n       = sent_inc;
            // corruption applies to the first frame only
            inj_n        = 1'b0;
            idx_n        = 2'd0;
            if (sent_inc == total) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else if (GAP_CYCLES == 0) begin
              state_n = SEND;
            end else begin
              gap_cnt_n = '0;
              state_n   = GAP;
            end
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = SEND;
        end else begin
          gap_cnt_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // outputs are registered from the next-state view so they line up with the state
    corrupt = inj_n && (idx_n == err_idx_n);
    valid_n = (state_n == SEND);
    busy_n  = (state_n != IDLE);
    sym_n   = valid_n ? (pattern_sym(idx_n) ^ {2'b00, corrupt}) : IDLE_SYM;
  end

endmodule
